// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the CPU execute stage.
// Contents:
//   ALU_WIDTH       default datapath width
//   OP_*            alu_func operation codes (12-15 reserved)
//   FLAG_*          bit positions inside the {N,Z,C,V} flag vector
//   alu_state_t     execute-stage FSM state encoding
package cpu_alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SAR   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_CMP   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier used by the execute stage for MUL.
// Only built when ALU_EXEC_MUL_EN is defined.
// Ports:
//   clk, rst      clock / asynchronous active-low reset
//   start         load operands and begin a new product (one-cycle pulse)
//   a, b          multiplicand / multiplier, sampled on start
//   done          high in the cycle whose rising edge performs the last step
//   product       2*WIDTH product as it will stand after the current step
`ifdef ALU_EXEC_MUL_EN
module alu_mul_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic               running;

    // The product is exposed one step early so the caller can register it
    // on the same edge that performs the final accumulation.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign product = acc_next;
    assign done    = running && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            acc     <= '0;
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_exec.sv
// Execute stage of the 16-bit CPU. Performs the decoded ALU operation on the
// operands from the operand mux and registers result, NZCV flags and the
// register-file write enable.
// Optional feature macro: ALU_EXEC_MUL_EN
//   defined   -> MUL runs on the multi-cycle shift-add multiplier, busy stalls
//   undefined -> MUL behaves like a reserved code, busy is tied low
// Ports:
//   clk, rst      clock / asynchronous active-low reset
//   en_in         operands valid
//   alu_func      operation code (see cpu_alu_pkg)
//   alu_a, alu_b  operands; shift amount is alu_b[SHAMT_W-1:0]
//   alu_out       registered result
//   flags         registered {N,Z,C,V}
//   wr_en         result is to be written to rd (pulses with en_out)
//   en_out        one-cycle result-valid pulse
//   busy          multi-cycle op in progress, upstream must stall
module alu_exec
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             wr_en,
    output logic             en_out,
    output logic             busy
);

    alu_state_t state_q;
    alu_state_t state_d;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     sar_ext;
    logic               add_ovf;
    logic               sub_ovf;

    logic [WIDTH-1:0]   dec_res;
    logic               dec_c;
    logic               dec_v;
    logic               dec_wr;

    logic               load;
    logic [WIDTH-1:0]   nxt_res;
    logic               nxt_c;
    logic               nxt_v;
    logic               nxt_wr;
    logic [3:0]         nxt_flags;

    assign shamt    = alu_b[SHAMT_W-1:0];
    assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
    assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};

    // Shifts run one bit wider than the datapath so the last bit shifted out
    // lands in the extra bit; with a zero amount that bit stays 0.
    assign shl_ext = {1'b0, alu_a} << shamt;
    assign shr_ext = {alu_a, 1'b0} >> shamt;
    assign sar_ext = $signed({alu_a, 1'b0}) >>> shamt;

    assign add_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_ext[WIDTH-1] != alu_a[WIDTH-1]);
    assign sub_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_ext[WIDTH-1] != alu_a[WIDTH-1]);

    // Single-cycle datapath. Anything not listed, including MUL, decodes as
    // reserved: zero result and no write-back; Z then follows from the zero.
    always_comb begin
        dec_res = '0;
        dec_c   = 1'b0;
        dec_v   = 1'b0;
        dec_wr  = 1'b1;
        case (alu_func)
            OP_ADD: begin
                dec_res = sum_ext[WIDTH-1:0];
                dec_c   = sum_ext[WIDTH];
                dec_v   = add_ovf;
            end
            OP_SUB, OP_CMP: begin
                dec_res = diff_ext[WIDTH-1:0];
                dec_c   = diff_ext[WIDTH];
                dec_v   = sub_ovf;
                dec_wr  = (alu_func != OP_CMP);
            end
            OP_AND:   dec_res = alu_a & alu_b;
            OP_OR:    dec_res = alu_a | alu_b;
            OP_XOR:   dec_res = alu_a ^ alu_b;
            OP_NOT:   dec_res = ~alu_a;
            OP_SHL: begin
                dec_res = shl_ext[WIDTH-1:0];
                dec_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                dec_res = shr_ext[WIDTH:1];
                dec_c   = shr_ext[0];
            end
            OP_SAR: begin
                dec_res = sar_ext[WIDTH:1];
                dec_c   = sar_ext[0];
            end
            OP_PASSB: dec_res = alu_b;
            default:  dec_wr  = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (alu_a),
        .b       (alu_b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = (state_q == ST_MUL_RUN);
`else
    assign busy = 1'b0;
`endif

    // Next-state and result selection. New operands are only accepted in
    // IDLE, so en_in during a multiply is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        nxt_res = dec_res;
        nxt_c   = dec_c;
        nxt_v   = dec_v;
        nxt_wr  = dec_wr;
`ifdef ALU_EXEC_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_in) begin
`ifdef ALU_EXEC_MUL_EN
                    if (alu_func == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_RUN;
                    end else begin
                        load = 1'b1;
                    end
`else
                    load = 1'b1;
`endif
                end
            end
            ST_MUL_RUN: begin
`ifdef ALU_EXEC_MUL_EN
                if (mul_done) begin
                    load    = 1'b1;
                    nxt_res = mul_product[WIDTH-1:0];
                    nxt_c   = |mul_product[2*WIDTH-1:WIDTH];
                    nxt_v   = 1'b0;
                    nxt_wr  = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_flags         = '0;
        nxt_flags[FLAG_N] = nxt_res[WIDTH-1];
        nxt_flags[FLAG_Z] = (nxt_res == '0);
        nxt_flags[FLAG_C] = nxt_c;
        nxt_flags[FLAG_V] = nxt_v;
    end

    // en_out and wr_en fall back to 0 every cycle that has no fresh result,
    // while alu_out and flags keep the last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            alu_out <= '0;
            flags   <= '0;
            wr_en   <= 1'b0;
            en_out  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en   <= 1'b0;
            en_out  <= 1'b0;
            if (load) begin
                alu_out <= nxt_res;
                flags   <= nxt_flags;
                wr_en   <= nxt_wr;
                en_out  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec. A behavioural model built from plain
// integer arithmetic supplies every expected value. Follows ALU_EXEC_MUL_EN
// so the same bench covers both builds.
module tb_alu_exec;

    localparam logic [3:0] F_ADD   = 4'd0;
    localparam logic [3:0] F_SUB   = 4'd1;
    localparam logic [3:0] F_XOR   = 4'd4;
    localparam logic [3:0] F_NOT   = 4'd5;
    localparam logic [3:0] F_SHL   = 4'd6;
    localparam logic [3:0] F_SAR   = 4'd8;
    localparam logic [3:0] F_CMP   = 4'd10;
    localparam logic [3:0] F_MUL   = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_in = 1'b0;
    logic [3:0]  alu_func = 4'd0;
    logic [15:0] alu_a = 16'h0;
    logic [15:0] alu_b = 16'h0;
    logic [15:0] alu_out;
    logic [3:0]  flags;
    logic        wr_en;
    logic        en_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk      (clk),
        .rst      (rst),
        .en_in    (en_in),
        .alu_func (alu_func),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .flags    (flags),
        .wr_en    (wr_en),
        .en_out   (en_out),
        .busy     (busy)
    );

    // Reference ALU: results from integer arithmetic, flags {N,Z,C,V}.
    function automatic void model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] fl, output logic w);
        int ua, ub, sa, sb, s, amt;
        longint p;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        amt = ub % 16;
        c = 1'b0;
        v = 1'b0;
        w = 1'b1;
        r = 16'h0;
        p = 0;
        case (f)
            4'd0: begin
                s = ua + ub; r = s[15:0]; c = (s > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            4'd1, 4'd10: begin
                s = ua - ub; r = s[15:0]; c = (ua < ub);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
                w = (f != 4'd10);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                s = ua << amt; r = s[15:0];
                c = (amt == 0) ? 1'b0 : (((ua >> (16 - amt)) & 1) != 0);
            end
            4'd7: begin
                s = ua >> amt; r = s[15:0];
                c = (amt == 0) ? 1'b0 : (((ua >> (amt - 1)) & 1) != 0);
            end
            4'd8: begin
                s = sa >>> amt; r = s[15:0];
                c = (amt == 0) ? 1'b0 : (((sa >>> (amt - 1)) & 1) != 0);
            end
            4'd9: r = b;
`ifdef ALU_EXEC_MUL_EN
            4'd11: begin
                p = longint'(ua) * longint'(ub);
                r = p[15:0];
                c = ((p >> 16) != 0);
            end
`endif
            default: w = 1'b0;
        endcase
        fl = {r[15], (r == 16'h0), c, v};
    endfunction

    function automatic logic [3:0] pick_func();
        logic [3:0] f;
        f = 4'($urandom_range(0, 15));
`ifdef ALU_EXEC_MUL_EN
        while (f == F_MUL) f = 4'($urandom_range(0, 15));
`endif
        return f;
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drives one op for a single cycle; returns at the falling edge after the
    // sampling edge, where its registered result is visible.
    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        alu_func = f;
        alu_a    = a;
        alu_b    = b;
        en_in    = 1'b1;
        @(negedge clk);
        en_in = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        en_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_out, flags} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h/%b expected 0000/0000", alu_out, flags);
        end
        checks++;
        if ({wr_en, en_out, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got wr_en/en_out/busy=%b expected 000", {wr_en, en_out, busy});
        end
        rst = 1'b1;
    endtask

    task automatic test_add_overflow();
        run_op(F_ADD, 16'h7FFF, 16'h0001);
        checks++;
        if (alu_out !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL add_ovf_result: got %h expected 8000", alu_out);
        end
        checks++;
        if (flags !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL add_ovf_flags: got %b expected 1001", flags);
        end
        checks++;
        if ({wr_en, en_out} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL add_ovf_ctrl: got wr_en/en_out=%b expected 11", {wr_en, en_out});
        end
        @(negedge clk);
        checks++;
        if ({wr_en, en_out} !== 2'b00 || alu_out !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL add_ovf_hold: got wr_en/en_out=%b out=%h expected 00 8000", {wr_en, en_out}, alu_out);
        end
    endtask

    task automatic test_cmp_sub();
        run_op(F_CMP, 16'h0003, 16'h0005);
        checks++;
        if (alu_out !== 16'hFFFE || flags !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL cmp: got %h/%b expected fffe/1010", alu_out, flags);
        end
        checks++;
        if ({wr_en, en_out} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL cmp_ctrl: got wr_en/en_out=%b expected 01", {wr_en, en_out});
        end
        run_op(F_SUB, 16'h1234, 16'h1234);
        checks++;
        if (alu_out !== 16'h0000 || flags !== 4'b0100 || wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_equal: got %h/%b wr=%b expected 0000/0100 wr=1", alu_out, flags, wr_en);
        end
    endtask

    task automatic test_shifts();
        logic [15:0] a;
        run_op(F_SAR, 16'h8001, 16'h0001);
        checks++;
        if (alu_out !== 16'hC000 || flags !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL sar: got %h/%b expected c000/1010", alu_out, flags);
        end
        a = 16'($urandom) | 16'h8001;
        run_op(F_SHL, a, 16'hFFF0);
        checks++;
        if (alu_out !== a || flags[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shl_zero: got %h C=%b expected %h C=0", alu_out, flags[1], a);
        end
    endtask

    task automatic test_random();
        logic [3:0]  f;
        logic [15:0] a, b, er;
        logic [3:0]  ef;
        logic        ew;
        for (int i = 0; i < 60; i++) begin
            f = pick_func();
            a = pick_operand();
            b = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : pick_operand();
            model(f, a, b, er, ef, ew);
            run_op(f, a, b);
            checks++;
            if (alu_out !== er || flags !== ef || wr_en !== ew || en_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL random op=%0d a=%h b=%h: got %h/%b wr=%b en=%b expected %h/%b wr=%b en=1",
                         f, a, b, alu_out, flags, wr_en, en_out, er, ef, ew);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [8];
        logic [15:0] er [8];
        logic [3:0]  ef [8];
        logic        ew [8];
        logic [15:0] a, b;
        ops[0] = F_ADD;
        ops[1] = F_XOR;
        ops[2] = F_NOT;
        for (int i = 3; i < 8; i++) ops[i] = pick_func();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (en_out !== 1'b1 || alu_out !== er[i-1] || flags !== ef[i-1] || wr_en !== ew[i-1]) begin
                    errors++;
                    $display("[TB] FAIL b2b[%0d]: got %h/%b wr=%b en=%b expected %h/%b wr=%b en=1",
                             i - 1, alu_out, flags, wr_en, en_out, er[i-1], ef[i-1], ew[i-1]);
                end
            end
            if (i < 8) begin
                a = 16'($urandom);
                b = 16'($urandom);
                model(ops[i], a, b, er[i], ef[i], ew[i]);
                alu_func = ops[i];
                alu_a    = a;
                alu_b    = b;
                en_in    = 1'b1;
            end else begin
                en_in = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (en_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got en_out=%b expected 0", en_out);
        end
    endtask

`ifdef ALU_EXEC_MUL_EN
    task automatic test_mul();
        int edges, busy_cnt;
        logic [15:0] a, b, er;
        logic [3:0]  ef;
        logic        ew;
        @(negedge clk);
        alu_func = F_MUL;
        alu_a    = 16'h0100;
        alu_b    = 16'h0101;
        en_in    = 1'b1;
        @(negedge clk);
        edges    = 1;
        busy_cnt = 0;
        while (en_out !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            en_in    = edges[0];
            alu_func = F_ADD;
            alu_a    = 16'h0001;
            alu_b    = 16'h0001;
            @(negedge clk);
            edges++;
        end
        en_in = 1'b0;
        checks++;
        if (edges != 17 || busy_cnt != 16) begin
            errors++;
            $display("[TB] FAIL mul_timing: got edges=%0d busy_cycles=%0d expected 17/16", edges, busy_cnt);
        end
        checks++;
        if (alu_out !== 16'h0100 || flags !== 4'b0010 || wr_en !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_result: got %h/%b wr=%b busy=%b expected 0100/0010 wr=1 busy=0",
                     alu_out, flags, wr_en, busy);
        end
        @(negedge clk);
        checks++;
        if (en_out !== 1'b0 || alu_out !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL mul_after: got en=%b out=%h expected 0 0100", en_out, alu_out);
        end
        for (int k = 0; k < 4; k++) begin
            a = pick_operand();
            b = 16'($urandom);
            model(F_MUL, a, b, er, ef, ew);
            run_op(F_MUL, a, b);
            edges = 1;
            while (en_out !== 1'b1 && edges < 40) begin
                @(negedge clk);
                edges++;
            end
            checks++;
            if (edges != 17 || alu_out !== er || flags !== ef || wr_en !== ew) begin
                errors++;
                $display("[TB] FAIL mul_random a=%h b=%h: got %h/%b wr=%b edges=%0d expected %h/%b wr=%b edges=17",
                         a, b, alu_out, flags, wr_en, edges, er, ef, ew);
            end
        end
    endtask
`else
    task automatic test_mul();
        run_op(F_MUL, 16'h0100, 16'h0101);
        checks++;
        if (alu_out !== 16'h0000 || flags !== 4'b0100 || {wr_en, en_out, busy} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL mul_reserved: got %h/%b wr/en/busy=%b expected 0000/0100 010",
                     alu_out, flags, {wr_en, en_out, busy});
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        int stray;
        run_op(F_ADD, 16'h0010, 16'h0001);
        @(negedge clk);
`ifdef ALU_EXEC_MUL_EN
        alu_func = F_MUL;
        alu_a    = 16'h0100;
        alu_b    = 16'h0101;
        en_in    = 1'b1;
        @(negedge clk);
        en_in = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_mul_busy: got %b expected 1", busy);
        end
`else
        alu_func = F_XOR;
        alu_a    = 16'h00FF;
        alu_b    = 16'h0F0F;
        en_in    = 1'b1;
        @(negedge clk);
        en_in = 1'b0;
`endif
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({alu_out, flags, wr_en, en_out, busy} !== 23'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got out=%h flags=%b wr/en/busy=%b expected all 0",
                     alu_out, flags, {wr_en, en_out, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(F_ADD, 16'h0002, 16'h0003);
        checks++;
        if (alu_out !== 16'h0005 || flags !== 4'b0000 || {wr_en, en_out} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL post_reset_add: got %h/%b wr/en=%b expected 0005/0000 11",
                     alu_out, flags, {wr_en, en_out});
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (en_out !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %0d cycles with en_out/busy set expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_cmp_sub();
        test_shifts();
        test_random();
        test_back_to_back();
        test_mul();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage of the 16-bit CPU; sits directly downstream of the ALU operand mux and consumes its alu_a/alu_b/en_out.
- Performs the decoded ALU operation and registers the result, NZCV flags and write-back enable for the register-file write stage.
- Single-cycle ops complete in 1 clock; MUL is a multi-cycle shift-add sequence with a busy stall output.

Parameters:
- WIDTH, 16, datapath width (operands, result); MUL iteration count equals WIDTH.
- SHAMT_W, 4, shift-amount bits taken from alu_b[SHAMT_W-1:0].

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en_in  input  1  operands valid (from operand mux en_out)
- alu_func  input  4  operation code
- alu_a  input  WIDTH  operand A (rd value)
- alu_b  input  WIDTH  operand B (rs value or sign-extended offset)
- alu_out  output  WIDTH  registered result
- flags  output  4  {N,Z,C,V}, registered
- wr_en  output  1  result should be written to rd
- en_out  output  1  one-cycle result-valid pulse
- busy  output  1  multi-cycle op in progress; upstream must stall

Behaviour:
- Reset (rst=0, any time incl. mid-MUL): alu_out=0, flags=0, wr_en=0, en_out=0, busy=0, state=IDLE, multiplier registers cleared.
- alu_func encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR (logical), 8 SAR, 9 PASSB, 10 CMP, 11 MUL, 12-15 reserved.
- States: IDLE, MUL_RUN. IDLE + en_in=1 + single-cycle op: at that edge, register result/flags/wr_en, en_out=1 for exactly the next cycle; stay IDLE. Back-to-back en_in each cycle gives one result per cycle.
- IDLE + en_in=1 + MUL: latch operands, busy=1, counter=0, go MUL_RUN. Each edge in MUL_RUN: one shift-add step, counter+1. At the WIDTH-th step edge: register result, en_out=1, busy=0, return IDLE. Latency WIDTH+1 edges from sample to en_out.
- en_in while busy=1: ignored; no operands captured.
- en_out, wr_en low in every cycle without a fresh result; alu_out/flags hold last value.
- Arithmetic: ADD/SUB computed WIDTH+1 bits. ADD C=carry out; SUB/CMP C=borrow (a<b unsigned); V=signed overflow. N=result MSB, Z=(result==0) for all ops.
- Logic ops, NOT, PASSB: C=0, V=0.
- Shifts: amount=alu_b[3:0]; C=last bit shifted out, 0 when amount=0; V=0. SAR replicates MSB.
- CMP: alu_out=a-b, flags as SUB, wr_en=0. All other valid ops wr_en=1.
- MUL: unsigned, alu_out=low WIDTH bits; C=1 if high WIDTH bits nonzero; V=0.
- Reserved codes: alu_out=0, flags=0 except Z=1, wr_en=0, en_out still pulses.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
- Defined: MUL multi-cycle path as above; busy functional.
- Undefined: multiplier and MUL_RUN not built; MUL handled as a reserved code (single cycle, wr_en=0); busy tied 0.

Decomposition:
- Package cpu_alu_pkg: alu_func opcode constants, flag bit indices (N=3, Z=2, C=1, V=0), state encoding, WIDTH default.
- Sub-module alu_mul_seq: shift-add multiplier with start/done handshake, producing a 2*WIDTH product; instantiated only under ALU_EXEC_MUL_EN.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001, en_in 1 cycle -> next cycle alu_out=16'h8000, flags N=1 Z=0 C=0 V=1, wr_en=1, en_out=1 for one cycle only.
- CMP a=16'h0003, b=16'h0005 -> alu_out=16'hFFFE, C=1 N=1, wr_en=0; then SUB a=b=16'h1234 -> Z=1 C=0.
- SAR a=16'h8001, b=16'h0001 -> alu_out=16'hC000, C=1; SHL with b=0 -> alu_out=a, C=0.
- MUL a=16'h0100, b=16'h0101 -> busy high 16 cycles, en_in pulses during busy ignored, en_out after 17 edges, alu_out=16'h0100, C=1.
- Reset asserted at MUL step 8 -> all outputs 0 immediately; after release, ADD 2+3 -> alu_out=5 next cycle.
- en_in held high, ops ADD, XOR, NOT back-to-back -> en_out high 3 consecutive cycles with matching results.
